// File: rtl/sprite_animator.sv
// Walking-character sprite animator: VS-driven facing/step state plus a 2-cycle
// sprite-sheet fetch pipeline. Define SPRITE_MIRROR_EN to draw "left" as mirrored "right".
module sprite_animator #(
    parameter int unsigned SPR_W      = 19,
    parameter int unsigned SPR_H      = 29,
    parameter int unsigned SHEET_W    = 228,
    parameter int unsigned FRAME_DIV  = 8,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned TRANSP_IDX = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              VS,
    input  logic              Moving,
    input  logic [1:0]        Direction,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_data,
    output logic              pix_valid,
    output logic [IDX_W-1:0]  pix_idx,
    output logic [1:0]        facing,
    output logic [1:0]        anim_step
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic       vs_s1, vs_s2, vs_prev;
    logic [1:0] sync_fill;
    logic       armed;
    logic       frame_tick;

    // armed only rises once the synchroniser holds a real VS sample that is low,
    // so a VS already high at reset release cannot masquerade as a rising edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_prev    <= 1'b0;
            sync_fill  <= '0;
            armed      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_s1      <= VS;
            vs_s2      <= vs_s1;
            vs_prev    <= vs_s2;
            sync_fill  <= {sync_fill[0], 1'b1};
            armed      <= armed | (sync_fill[1] & ~vs_s2);
            frame_tick <= armed & vs_s2 & ~vs_prev;
        end
    end

    dir_t             facing_q, facing_d;
    logic [1:0]       step_q, step_d;
    logic [DIV_W-1:0] div_q, div_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            facing_q <= DIR_UP;
            step_q   <= '0;
            div_q    <= '0;
        end else begin
            facing_q <= facing_d;
            step_q   <= step_d;
            div_q    <= div_d;
        end
    end

    always_comb begin
        facing_d = facing_q;
        step_d   = step_q;
        div_d    = div_q;
        if (frame_tick) begin
            if (!Moving) begin
                step_d = '0;
                div_d  = '0;
            end else if (dir_t'(Direction) != facing_q) begin
                facing_d = dir_t'(Direction);
                step_d   = '0;
                div_d    = '0;
            end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d  = '0;
                step_d = step_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign facing    = facing_q;
    assign anim_step = step_q;

    logic [1:0] step_col;
    logic [3:0] base_col;
    logic [3:0] frame_col;

    always_comb begin
        case (step_q)
            2'd1:    step_col = 2'd0;
            2'd3:    step_col = 2'd2;
            default: step_col = 2'd1;
        endcase
    end

    always_comb begin
        case (facing_q)
            DIR_DOWN:  base_col = 4'd0;
`ifdef SPRITE_MIRROR_EN
            DIR_LEFT:  base_col = 4'd9;
`else
            DIR_LEFT:  base_col = 4'd3;
`endif
            DIR_UP:    base_col = 4'd6;
            default:   base_col = 4'd9;
        endcase
        frame_col = base_col + {2'b00, step_col};
    end

    logic [9:0]  dx, dy, x_off;
    logic [10:0] x_end, y_end;
    logic        hit;
    logic [ADDR_W-1:0] addr_calc;

    // Upper bounds in 11 bits so a sprite hanging off the right/bottom edge never wraps to 0.
    always_comb begin
        dx    = DrawX - SprX;
        dy    = DrawY - SprY;
        x_end = {1'b0, SprX} + 11'(SPR_W - 1);
        y_end = {1'b0, SprY} + 11'(SPR_H - 1);
        hit   = (DrawX >= SprX) && ({1'b0, DrawX} <= x_end) &&
                (DrawY >= SprY) && ({1'b0, DrawY} <= y_end);
`ifdef SPRITE_MIRROR_EN
        x_off = (facing_q == DIR_LEFT) ? (10'(SPR_W - 1) - dx) : dx;
`else
        x_off = dx;
`endif
        addr_calc = ADDR_W'(SHEET_W) * ADDR_W'(dy)
                  + ADDR_W'(frame_col) * ADDR_W'(SPR_W)
                  + ADDR_W'(x_off);
    end

    logic hit_d1, hit_d2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit_d1   <= 1'b0;
            hit_d2   <= 1'b0;
        end else begin
            rom_addr <= hit ? addr_calc : '0;
            hit_d1   <= hit;
            hit_d2   <= hit_d1;
        end
    end

    assign pix_valid = hit_d2 && (rom_data != IDX_W'(TRANSP_IDX));
    assign pix_idx   = pix_valid ? rom_data : '0;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed self-checking bench for sprite_animator; rom_data is driven directly by the bench.
module tb_sprite_animator;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        VS;
    logic        Moving;
    logic [1:0]  Direction;
    logic [9:0]  SprX, SprY, DrawX, DrawY;
    logic [12:0] rom_addr;
    logic [5:0]  rom_data;
    logic        pix_valid;
    logic [5:0]  pix_idx;
    logic [1:0]  facing;
    logic [1:0]  anim_step;

    int checks = 0;
    int errors = 0;

    sprite_animator #(
        .SPR_W(19), .SPR_H(29), .SHEET_W(228), .FRAME_DIV(8),
        .ADDR_W(13), .IDX_W(6), .TRANSP_IDX(6)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .VS(VS), .Moving(Moving), .Direction(Direction),
        .SprX(SprX), .SprY(SprY), .DrawX(DrawX), .DrawY(DrawY),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid), .pix_idx(pix_idx),
        .facing(facing), .anim_step(anim_step)
    );

    always #5 Clk = ~Clk;

    task automatic pulse_vs(input int n);
        for (int i = 0; i < n; i++) begin
            VS = 1'b1;
            repeat (5) @(negedge Clk);
            VS = 1'b0;
            repeat (5) @(negedge Clk);
        end
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
        @(negedge Clk);
        DrawX = x;
        DrawY = y;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; VS = 1'b0; Moving = 1'b0; Direction = 2'd0;
        SprX = 10'd311; SprY = 10'd340; DrawX = 10'd311; DrawY = 10'd340; rom_data = 6'd3;
        repeat (3) @(negedge Clk);
        checks++; if (facing !== 2'd0) begin errors++; $display("FAIL reset_facing: got %0d expected 0", facing); end
        checks++; if (anim_step !== 2'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", anim_step); end
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
        checks++; if (pix_valid !== 1'b0 || pix_idx !== 6'd0) begin errors++; $display("FAIL reset_pix: got %0b/%0d expected 0/0", pix_valid, pix_idx); end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++; if (rom_addr !== 13'd133) begin errors++; $display("FAIL first_addr: got %0d expected 133", rom_addr); end
    endtask

    task automatic test_walk;
        Moving = 1'b1; Direction = 2'd0;
        pulse_vs(7);
        checks++; if (anim_step !== 2'd0) begin errors++; $display("FAIL walk_7ticks: got %0d expected 0", anim_step); end
        pulse_vs(1);
        checks++; if (anim_step !== 2'd1) begin errors++; $display("FAIL walk_8ticks: got %0d expected 1", anim_step); end
        set_pix(10'd311, 10'd341);
        checks++; if (rom_addr !== 13'd342) begin errors++; $display("FAIL walk_m1_addr: got %0d expected 342", rom_addr); end
        pulse_vs(8);
        set_pix(10'd311, 10'd340);
        checks++; if (anim_step !== 2'd2 || rom_addr !== 13'd133) begin errors++; $display("FAIL walk_step2: got step %0d addr %0d expected 2/133", anim_step, rom_addr); end
        pulse_vs(8);
        set_pix(10'd311, 10'd340);
        checks++; if (anim_step !== 2'd3 || rom_addr !== 13'd152) begin errors++; $display("FAIL walk_step3: got step %0d addr %0d expected 3/152", anim_step, rom_addr); end
        pulse_vs(8);
        checks++; if (anim_step !== 2'd0 || facing !== 2'd0) begin errors++; $display("FAIL walk_wrap: got step %0d facing %0d expected 0/0", anim_step, facing); end
    endtask

    task automatic test_idle;
        pulse_vs(4);
        Moving = 1'b0;
        pulse_vs(1);
        Moving = 1'b1;
        pulse_vs(7);
        checks++; if (anim_step !== 2'd0) begin errors++; $display("FAIL idle_div_clear: got %0d expected 0", anim_step); end
        pulse_vs(1);
        checks++; if (anim_step !== 2'd1) begin errors++; $display("FAIL idle_resume: got %0d expected 1", anim_step); end
        Moving = 1'b0;
        pulse_vs(1);
        checks++; if (anim_step !== 2'd0 || facing !== 2'd0) begin errors++; $display("FAIL idle_stop: got step %0d facing %0d expected 0/0", anim_step, facing); end
    endtask

    task automatic test_bounds;
        set_pix(10'd330, 10'd340);
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL miss_right: got %0d expected 0", rom_addr); end
        set_pix(10'd311, 10'd369);
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL miss_below: got %0d expected 0", rom_addr); end
        set_pix(10'd310, 10'd340);
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL miss_left: got %0d expected 0", rom_addr); end
        set_pix(10'd311, 10'd339);
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL miss_above: got %0d expected 0", rom_addr); end
        set_pix(10'd329, 10'd368);
        checks++; if (rom_addr !== 13'd6535) begin errors++; $display("FAIL corner_addr: got %0d expected 6535", rom_addr); end
        SprX = 10'd1015;
        set_pix(10'd1020, 10'd340);
        checks++; if (rom_addr !== 13'd138) begin errors++; $display("FAIL edge_hit: got %0d expected 138", rom_addr); end
        set_pix(10'd2, 10'd340);
        checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL edge_nowrap: got %0d expected 0", rom_addr); end
        SprX = 10'd311;
    endtask

    task automatic test_pixel;
        rom_data = 6'd3;
        set_pix(10'd330, 10'd340);
        @(negedge Clk);
        checks++; if (pix_valid !== 1'b0 || pix_idx !== 6'd0) begin errors++; $display("FAIL miss_pix: got %0b/%0d expected 0/0", pix_valid, pix_idx); end
        DrawX = 10'd311; DrawY = 10'd340;
        @(negedge Clk);
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL pix_latency1: got %0b expected 0", pix_valid); end
        @(negedge Clk);
        checks++; if (pix_valid !== 1'b1 || pix_idx !== 6'd3) begin errors++; $display("FAIL pix_opaque: got %0b/%0d expected 1/3", pix_valid, pix_idx); end
        rom_data = 6'd6;
        #1;
        checks++; if (pix_valid !== 1'b0 || pix_idx !== 6'd0) begin errors++; $display("FAIL pix_transp: got %0b/%0d expected 0/0", pix_valid, pix_idx); end
        rom_data = 6'd3;
    endtask

    task automatic test_turn;
        Moving = 1'b1; Direction = 2'd0;
        pulse_vs(3);
        Direction = 2'd2;
        pulse_vs(1);
        set_pix(10'd311, 10'd340);
        checks++; if (facing !== 2'd2 || anim_step !== 2'd0) begin errors++; $display("FAIL turn_state: got facing %0d step %0d expected 2/0", facing, anim_step); end
        checks++; if (rom_addr !== 13'd19) begin errors++; $display("FAIL turn_addr: got %0d expected 19", rom_addr); end
    endtask

    task automatic test_left;
        logic [12:0] exp_addr;
`ifdef SPRITE_MIRROR_EN
        exp_addr = 13'd208;
`else
        exp_addr = 13'd76;
`endif
        Direction = 2'd3;
        pulse_vs(1);
        set_pix(10'd311, 10'd340);
        checks++; if (facing !== 2'd3 || anim_step !== 2'd0) begin errors++; $display("FAIL left_state: got facing %0d step %0d expected 3/0", facing, anim_step); end
        checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL left_addr: got %0d expected %0d", rom_addr, exp_addr); end
    endtask

    task automatic test_async_reset;
        pulse_vs(8);
        set_pix(10'd311, 10'd340);
        @(negedge Clk);
        checks++; if (anim_step !== 2'd1 || pix_valid !== 1'b1 || rom_addr === 13'd0) begin errors++; $display("FAIL pre_reset: got step %0d valid %0b addr %0d expected 1/1/nonzero", anim_step, pix_valid, rom_addr); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (facing !== 2'd0 || anim_step !== 2'd0) begin errors++; $display("FAIL async_state: got facing %0d step %0d expected 0/0", facing, anim_step); end
        checks++; if (rom_addr !== 13'd0 || pix_valid !== 1'b0 || pix_idx !== 6'd0) begin errors++; $display("FAIL async_out: got addr %0d valid %0b idx %0d expected 0/0/0", rom_addr, pix_valid, pix_idx); end
        VS = 1'b1;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (10) @(negedge Clk);
        checks++; if (facing !== 2'd0) begin errors++; $display("FAIL no_stale_tick: got facing %0d expected 0", facing); end
        VS = 1'b0;
        repeat (5) @(negedge Clk);
        VS = 1'b1;
        repeat (5) @(negedge Clk);
        checks++; if (facing !== 2'd3) begin errors++; $display("FAIL fresh_tick: got facing %0d expected 3", facing); end
        VS = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_idle();
        test_bounds();
        test_pixel();
        test_turn();
        test_left();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
